// File: rtl/serial_operand_loader.sv
// Serial-to-parallel operand loader feeding the equality comparator over a valid/ready handshake.
// Optional registered a==b result is enabled with the CAPTURE_MATCH_EN macro.
module serial_operand_loader #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sa,
  input  logic             sb,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
`ifdef CAPTURE_MATCH_EN
  output logic             busy,
  output logic             match
`else
  output logic             busy
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: a pair transfers on any rising edge where out_valid and out_ready
  // are both high; a/b stay frozen from out_valid rising until that edge.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    a_nxt     = a;
    b_nxt     = b;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        a_nxt = {a[WIDTH-2:0], sa};
        b_nxt = {b[WIDTH-2:0], sb};
        if (cnt == LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HOLD: begin
        // start only counts when it coincides with the transfer edge
        if (out_ready) begin
          state_nxt = start ? SHIFT : IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      a         <= '0;
      b         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      out_valid <= (state_nxt == HOLD);
      busy      <= (state_nxt != IDLE);
    end
  end

`ifdef CAPTURE_MATCH_EN
  // Loaded from the post-shift words so it rises together with out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      match <= 1'b0;
    end else if (state == SHIFT && cnt == LAST) begin
      match <= (a_nxt == b_nxt);
    end else if (state_nxt != HOLD) begin
      match <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_serial_operand_loader.sv
// Directed self-checking bench for serial_operand_loader (default WIDTH=5).
module tb_serial_operand_loader;

  localparam int W = 5;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sa;
  logic         sb;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
`ifdef CAPTURE_MATCH_EN
  logic         match;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: each completed load pushes {a,b}; each transfer pops and compares.
  logic [2*W-1:0] exp_q[$];

  serial_operand_loader #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sa        (sa),
    .sb        (sb),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .a         (a),
    .b         (b),
`ifdef CAPTURE_MATCH_EN
    .busy      (busy),
    .match     (match)
`else
    .busy      (busy)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drivers: apply inputs, then sample 1 time unit after the rising edge.
  task automatic cycle(input logic st, input logic ba, input logic bb, input logic rdy);
    start     = st;
    sa        = ba;
    sb        = bb;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_match(input logic exp);
`ifdef CAPTURE_MATCH_EN
    check("match", {31'd0, match}, {31'd0, exp});
`else
    if (exp === 1'bx) $display("unreachable");
`endif
  endtask

  // Shift W bit pairs MSB first; noise pulses start/out_ready, which must be ignored.
  task automatic shift_bits(input logic [W-1:0] av, input logic [W-1:0] bv, input logic noise);
    for (int i = W - 1; i >= 0; i--) begin
      cycle(noise ? i[0] : 1'b0, av[i], bv[i], noise);
      if (i > 0) begin
        check("valid_shift", {31'd0, out_valid}, 32'd0);
        check("busy_shift", {31'd0, busy}, 32'd1);
        check_match(1'b0);
      end
    end
    check("valid_done", {31'd0, out_valid}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd1);
    check("a_done", {27'd0, a}, {27'd0, av});
    check("b_done", {27'd0, b}, {27'd0, bv});
    check_match(av == bv);
    exp_q.push_back({av, bv});
  endtask

  task automatic load(input logic [W-1:0] av, input logic [W-1:0] bv, input logic noise);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("valid_start", {31'd0, out_valid}, 32'd0);
    check("busy_start", {31'd0, busy}, 32'd1);
    shift_bits(av, bv, noise);
  endtask

  task automatic transfer(input logic st);
    logic [2*W-1:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check("sb_a", {27'd0, a}, {27'd0, e[2*W-1:W]});
    check("sb_b", {27'd0, b}, {27'd0, e[W-1:0]});
    cycle(st, 1'b0, 1'b0, 1'b1);
    check("valid_xfer", {31'd0, out_valid}, 32'd0);
    check("busy_xfer", {31'd0, busy}, {31'd0, st});
    check_match(1'b0);
    if (!st) begin
      check("a_keep", {27'd0, a}, {27'd0, e[2*W-1:W]});
      check("b_keep", {27'd0, b}, {27'd0, e[W-1:0]});
    end
  endtask

  initial begin
    start = 0; sa = 0; sb = 0; out_ready = 0;

    // Reset, then idle
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      check("idle_a", {27'd0, a}, 32'd0);
      check("idle_b", {27'd0, b}, 32'd0);
      check("idle_valid", {31'd0, out_valid}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check_match(1'b0);
    end
    // out_ready while nothing is valid has no effect
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("idle_rdy_valid", {31'd0, out_valid}, 32'd0);
    check("idle_rdy_busy", {31'd0, busy}, 32'd0);

    // Basic load, then hold with out_ready low (one cycle also raises start)
    load(5'b00101, 5'b00011, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(i == 1, 1'b1, 1'b0, 1'b0);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_busy", {31'd0, busy}, 32'd1);
      check("hold_a", {27'd0, a}, 32'h05);
      check("hold_b", {27'd0, b}, 32'h03);
      check_match(1'b0);
    end
    transfer(1'b0);

    // Equal operands
    load(5'b11111, 5'b11111, 1'b0);
    transfer(1'b0);
    check("eq_a_after", {27'd0, a}, 32'h1f);

    // Back-to-back: transfer and start on the same edge
    load(5'b10101, 5'b01010, 1'b0);
    transfer(1'b1);
    shift_bits(5'b00001, 5'b00001, 1'b0);
    transfer(1'b0);

    // Reset after 3 shifted bits
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    check("rst_a", {27'd0, a}, 32'd0);
    check("rst_b", {27'd0, b}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_idle_busy", {31'd0, busy}, 32'd0);
    load(5'b00110, 5'b00110, 1'b0);
    transfer(1'b0);

    // start and out_ready toggling during SHIFT must not disturb the count
    load(5'b10011, 5'b01101, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("noise_hold_valid", {31'd0, out_valid}, 32'd1);
    transfer(1'b0);

    check("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
